// File: rtl/button_pulser.sv
// button_pulser: debounced two-button pulse generator.
// Each raw button level passes through a 2-flop synchronizer, then a
// per-channel debounce FSM. The FSM raises a one-cycle pulse when a press
// is accepted. The top registers both pulses. If both would fire in the
// same cycle, neither is shown.
// Optional feature: define BUTTON_PULSER_AUTO_REPEAT_EN to add auto-repeat
// while a button is held. The first repeat comes after REPEAT_DELAY cycles,
// then one every REPEAT_PERIOD cycles. Without the macro, each accepted
// press gives exactly one pulse and no repeat logic is built.

module button_pulser_chan #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned CW = 21;
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    // Parameter legality is checked at elaboration time.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_debounce
        $error("button_pulser: DEBOUNCE_CYCLES out of range 2..2^20");
    end
    if (REPEAT_DELAY < 2 || REPEAT_DELAY > (1 << 20)) begin : g_bad_delay
        $error("button_pulser: REPEAT_DELAY out of range 2..2^20");
    end
    if (REPEAT_PERIOD < 2 || REPEAT_PERIOD > (1 << 20)) begin : g_bad_period
        $error("button_pulser: REPEAT_PERIOD out of range 2..2^20");
    end

    logic [1:0]    sync_q;
    logic          btn_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] save_q, save_d;
    logic          pulse_d;

`ifdef BUTTON_PULSER_AUTO_REPEAT_EN
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

    // rep_q is set once the first repeat has fired. Later repeats then use
    // REPEAT_PERIOD instead of REPEAT_DELAY.
    logic          rep_q, rep_d;
    logic [CW-1:0] rep_last;

    assign rep_last = rep_q ? PERIOD_LAST : DELAY_LAST;
`endif

    assign btn_s   = sync_q[1];
    assign pulse_o = pulse_d;

    // Two-flop synchronizer for the raw, asynchronous button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    // FSM state, cycle counter and the hold count saved across a release bounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            save_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            save_q  <= save_d;
        end
    end

`ifdef BUTTON_PULSER_AUTO_REPEAT_EN
    // Tracks whether the repeat schedule has moved from the delay phase to the period phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= 1'b0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    // Next-state logic, counter updates and the channel pulse request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        save_d  = save_q;
        pulse_d = 1'b0;
`ifdef BUTTON_PULSER_AUTO_REPEAT_EN
        rep_d   = rep_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = ONE;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
`ifdef BUTTON_PULSER_AUTO_REPEAT_EN
                    rep_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    // Save the hold count so that a bounce back to HELD resumes the schedule.
                    state_d = RELEASE_WAIT;
                    save_d  = cnt_q;
                    cnt_d   = ONE;
                end else begin
`ifdef BUTTON_PULSER_AUTO_REPEAT_EN
                    if (cnt_q == rep_last) begin
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                        rep_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
`else
                    // Saturate so that a very long hold never wraps the counter.
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + ONE;
                    end
`endif
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = save_q;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

module button_pulser #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_minus,
    input  logic btn_plus,
    output logic minus,
    output logic plus
);

    logic minus_pulse;
    logic plus_pulse;
    logic minus_q;
    logic plus_q;

    button_pulser_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_minus (
        .clk     (clk),
        .rst_n   (reset),
        .btn_i   (btn_minus),
        .pulse_o (minus_pulse)
    );

    button_pulser_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_plus (
        .clk     (clk),
        .rst_n   (reset),
        .btn_i   (btn_plus),
        .pulse_o (plus_pulse)
    );

    // Register the pulses. Simultaneous requests cancel so that the outputs never both go high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            minus_q <= 1'b0;
            plus_q  <= 1'b0;
        end else begin
            minus_q <= minus_pulse & ~plus_pulse;
            plus_q  <= plus_pulse & ~minus_pulse;
        end
    end

    assign minus = minus_q;
    assign plus  = plus_q;

endmodule

// File: tb/tb_button_pulser.sv
// Testbench for button_pulser (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5).
// Expected pulse cycles are queued when stimulus is applied. The monitor
// pops and compares them when the DUT pulses.
// The expectations follow BUTTON_PULSER_AUTO_REPEAT_EN when it is defined.

module tb_button_pulser;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic clk;
    logic reset;
    logic btn_minus;
    logic btn_plus;
    logic minus;
    logic plus;

    int cyc;
    int n_checks;
    int n_errors;
    int exp_plus_q[$];
    int exp_minus_q[$];

    button_pulser #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_minus (btn_minus),
        .btn_plus  (btn_plus),
        .minus     (minus),
        .plus      (plus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle k is the interval after the k-th rising edge.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A clean press whose raw level goes high in cycle t0 and stays high for
    // len cycles. The first pulse comes at t0+DB+2. The FSM stays in HELD
    // through cycle t0+len+2. Repeats follow at +RD, then every RP.
    task automatic expect_hold(input bit is_plus, input int t0, input int len);
        int t;
        int last;
        last = t0 + len + 2;
        t = t0 + DB + 2;
        if (is_plus) exp_plus_q.push_back(t); else exp_minus_q.push_back(t);
`ifdef BUTTON_PULSER_AUTO_REPEAT_EN
        t = t + RD;
        while (t <= last) begin
            if (is_plus) exp_plus_q.push_back(t); else exp_minus_q.push_back(t);
            t = t + RP;
        end
`else
        if (last < 0) n_errors++;
`endif
    endtask

    // Monitor: check output exclusivity, missed pulses and pulse timing.
    always @(negedge clk) begin
        check("excl", int'(plus & minus), 0);
        while (exp_plus_q.size() > 0 && exp_plus_q[0] < cyc) begin
            check("plus_miss", cyc, exp_plus_q[0]);
            void'(exp_plus_q.pop_front());
        end
        while (exp_minus_q.size() > 0 && exp_minus_q[0] < cyc) begin
            check("minus_miss", cyc, exp_minus_q[0]);
            void'(exp_minus_q.pop_front());
        end
        if (plus) begin
            if (exp_plus_q.size() == 0) check("plus_unexp", cyc, -1);
            else check("plus_cyc", cyc, exp_plus_q.pop_front());
        end
        if (minus) begin
            if (exp_minus_q.size() == 0) check("minus_unexp", cyc, -1);
            else check("minus_cyc", cyc, exp_minus_q.pop_front());
        end
    end

    initial begin
        int t0;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        btn_minus = 1'b0;
        btn_plus  = 1'b0;
        idle(3);
        check("rst_minus", int'(minus), 0);
        check("rst_plus", int'(plus), 0);
        reset = 1'b1;
        idle(5);

        // Clean plus press held for 30 cycles.
        t0 = cyc;
        expect_hold(1'b1, t0, 30);
        btn_plus = 1'b1;
        idle(30);
        btn_plus = 1'b0;
        idle(12);

        // Minus bursts of 3 high / 1 low: these never qualify.
        for (int i = 0; i < 5; i++) begin
            btn_minus = 1'b1;
            idle(3);
            btn_minus = 1'b0;
            idle(1);
        end
        idle(10);

        // Minus held for 40 cycles.
        t0 = cyc;
        expect_hold(1'b0, t0, 40);
        btn_minus = 1'b1;
        idle(40);
        btn_minus = 1'b0;
        idle(15);

        // Both pressed together: both pulses are suppressed. Then plus alone.
        btn_minus = 1'b1;
        btn_plus  = 1'b1;
        idle(20);
        btn_minus = 1'b0;
        btn_plus  = 1'b0;
        idle(10);
        t0 = cyc;
        expect_hold(1'b1, t0, 12);
        btn_plus = 1'b1;
        idle(12);
        btn_plus = 1'b0;
        idle(10);

        // Reset pulse in the middle of qualifying a held button.
        t0 = cyc;
        btn_plus = 1'b1;
        idle(5);
        reset = 1'b0;
        idle(1);
        check("rst_hold_plus", int'(plus), 0);
        idle(1);
        reset = 1'b1;
        expect_hold(1'b1, t0 + 7, 13);
        idle(13);
        btn_plus = 1'b0;
        idle(10);

        // Press of exactly DB cycles is the shortest that qualifies.
        t0 = cyc;
        expect_hold(1'b1, t0, DB);
        btn_plus = 1'b1;
        idle(DB);
        btn_plus = 1'b0;
        idle(10);

        // Release with a 2-cycle bounce back high inside RELEASE_WAIT.
        t0 = cyc;
        expect_hold(1'b1, t0, 10);
        btn_plus = 1'b1;
        idle(10);
        btn_plus = 1'b0;
        idle(1);
        btn_plus = 1'b1;
        idle(2);
        btn_plus = 1'b0;
        idle(15);

        check("plus_left", exp_plus_q.size(), 0);
        check("minus_left", exp_minus_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
